// File: rtl/a0_trace_uart.sv
// a0_trace_uart: captures every change of the CPU a0 value into a FIFO and prints each as 8 hex chars plus LF on a UART TX line
module a0_trace_uart #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   a0,
  input  logic                          en,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   last_q, sv;
  logic [3:0]    char_idx;
  logic [2:0]    bit_idx;
  logic [BW-1:0] baud;
  logic          cap, pop, push, tick;
  logic [3:0]    nib;
  logic [7:0]    ch;
  assign tick = baud == BW'(CLKS_PER_BIT - 1);
  assign pop  = state == IDLE && level != '0;
  assign cap  = en && a0 != last_q;
  assign push = cap && (level != LW'(FIFO_DEPTH) || pop);
  // sv is shifted left one nibble per character, so the current nibble is always the top one
  assign nib  = sv[31:28];
  assign ch   = char_idx[3] ? 8'h0A : (nib < 4'd10 ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib});
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= a0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
      level    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last_q   <= '0;
      sv       <= '0;
      char_idx <= '0;
      bit_idx  <= '0;
      baud     <= '0;
    end else begin
      if (cap) last_q <= a0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (cap && !push) overflow <= 1'b1;
      level <= level + LW'(push) - LW'(pop);
      baud  <= (state == IDLE || tick) ? '0 : baud + 1'b1;
      case (state)
        IDLE: if (pop) begin
          sv       <= mem[rd_ptr];
          char_idx <= '0;
          busy     <= 1'b1;
          tx       <= 1'b0;
          state    <= START;
        end
        START: if (tick) begin
          tx      <= ch[0];
          bit_idx <= '0;
          state   <= DATA;
        end
        DATA: if (tick) begin
          bit_idx <= bit_idx + 1'b1;
          tx      <= bit_idx == 3'd7 ? 1'b1 : ch[bit_idx + 3'd1];
          state   <= bit_idx == 3'd7 ? STOP : DATA;
        end
        STOP: if (tick) begin
          if (char_idx != 4'd8) begin
            char_idx <= char_idx + 1'b1;
            sv       <= sv << 4;
            tx       <= 1'b0;
            state    <= START;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
